pattern_mem_ctrl: RTL and testbench
===================================

Name: pattern_mem_ctrl

Overview:
- Parametrised successor to the tester's block-RAM controller.
- Holds the pattern memory regions for the ASIC tester: per-template words, forcing-format (FF) word pairs, template-cycle (TC) vectors, and an input-vector FIFO.
- Adds sizing generics, FIFO occupancy and full/empty flags, an error flag, and template-change detection.
- Sits between the host command decoder and the vector sequencer, using a single-strobe / READY handshake.

Parameters:
- DATA_W, 128, width of each stored word and of the read/write data buses.
- TSEL_W, 2, template-select width; number of templates N_TMPL = 2**TSEL_W.
- IN_AW, 4, input-FIFO address width; FIFO depth = 2**IN_AW.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- INPUT_WRITE  in  1  strobe: push WRITE_DATA_0 into the input FIFO.
- TEMPLATE_WRITE  in  1  strobe: write a template word.
- FF_WRITE  in  1  strobe: write an FF pair.
- TC_WRITE  in  1  strobe: write a TC vector.
- INPUT_READ  in  1  strobe: pop the input FIFO.
- TEMPLATE_READ  in  1  strobe: read template[TEMPLATE_BITS].
- FF_READ  in  1  strobe: read FF pair[TEMPLATE_BITS].
- TC_READ  in  1  strobe: read TC[TEMPLATE_BITS].
- TEMPLATE_BITS  in  TSEL_W  template select for reads.
- WRITE_DATA_0  in  DATA_W  write data, word 0.
- WRITE_DATA_1  in  DATA_W  write data, word 1 (FF only).
- READ_DATA_0  out  DATA_W  read data, word 0.
- READ_DATA_1  out  DATA_W  read data, word 1 (FF only; otherwise holds its last value).
- READY  out  1  high when idle and able to accept a command.
- TEMPLATE_CHANGE  out  1  one-cycle pulse coincident with READY rising after a read; see Behaviour.
- IN_COUNT  out  IN_AW+1  input-FIFO occupancy.
- IN_FULL  out  1  IN_COUNT == 2**IN_AW.
- IN_EMPTY  out  1  IN_COUNT == 0.
- ERR  out  1  sticky error flag; cleared only by RST.

Behaviour:
- Reset (RST high at an edge):
  - READY=1; READ_DATA_0/1=0; TEMPLATE_CHANGE=0; ERR=0.
  - FIFO pointers and IN_COUNT=0, so IN_EMPTY=1 and IN_FULL=0.
  - Last-template register = 0; FSM goes to IDLE.
  - Memory contents are not cleared.
  - Reset mid-operation aborts the command; a write in progress may or may not commit.
- Command acceptance:
  - A command is accepted at an edge where READY=1 and at least one strobe is high.
  - Priority order: INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE, INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ.
  - More than one strobe high: the highest-priority command executes and ERR is set.
  - Strobes while READY=0 are ignored and do not set ERR.
- Write index:
  - TEMPLATE_WRITE and TC_WRITE: index = WRITE_DATA_0[DATA_W-1 -: TSEL_W].
  - FF_WRITE: index = WRITE_DATA_1[DATA_W-1 -: TSEL_W].
  - Full words are stored, including the index bits.
- FSM states: IDLE, WRITE, RD_ADDR, RD_WAIT, DONE. RAMs are synchronous with 1-cycle read latency.
  - Write: IDLE→WRITE→IDLE. READY is low for exactly 1 cycle after the accept edge (total latency 2 edges).
  - Read: IDLE→RD_ADDR→RD_WAIT→DONE→IDLE. READY is low for 3 cycles. READ_DATA updates on the edge that enters IDLE and is held until the next read completes.
- Input FIFO:
  - Circular buffer; pointers wrap modulo 2**IN_AW.
  - INPUT_WRITE when IN_FULL: no push, ERR set, normal write timing.
  - INPUT_READ when IN_EMPTY: no pop, READ_DATA unchanged, ERR set, normal read timing.
  - IN_COUNT updates on the WRITE/DONE edge.
- Template change:
  - For TEMPLATE_READ, FF_READ and TC_READ, the selection is TEMPLATE_BITS sampled at accept.
  - For INPUT_READ (non-empty), the selection is the popped word's top TSEL_W bits.
  - If the selection differs from the last-template register, TEMPLATE_CHANGE pulses for 1 cycle together with READY rising.
  - The register is then updated to the selection.
  - An empty-FIFO read does not update the register.

Test Plan:
- TC_WRITE with D0=0x0123FEEDDEADBEEF0123FEEDDEADBEEF, then TC_READ with TEMPLATE_BITS=0 → READ_DATA_0 equals that value; READY low exactly 3 cycles; TEMPLATE_CHANGE=0.
- TEMPLATE_WRITE 0x0123… then 0xC123…; read TEMPLATE_BITS=3 → 0xC123…, TEMPLATE_CHANGE pulses; read TEMPLATE_BITS=0 → 0x0123…, TEMPLATE_CHANGE pulses again.
- FF_WRITE with D0=0x0123…, D1=0xC123…; FF_READ with TEMPLATE_BITS=3 → READ_DATA_0=0x0123… and READ_DATA_1=0xC123….
- Push 0x0123… then 0xFEED…AAAA; pop twice → data returned in order; IN_COUNT goes 2→1→0; IN_EMPTY=1 at end; second pop (top bits 11) raises TEMPLATE_CHANGE.
- Fill 16 entries → IN_FULL=1; 17th push → ERR=1 and IN_COUNT stays 16; drain 16 entries, verifying order across pointer wrap; 17th pop → ERR remains set and READ_DATA unchanged.
- TEMPLATE_READ and TC_READ asserted in the same cycle → template read executes and ERR=1; strobe asserted while READY=0 → ignored; RST mid-read → READY=1 and outputs reset on the next edge.

Source files
------------

// File: rtl/pattern_mem_ctrl.sv
// rtl/pattern_mem_ctrl.sv - tester pattern memories (template, FF pair, TC, input FIFO) behind a strobe/READY handshake
module pattern_mem_ctrl #(
   parameter int DATA_W = 128,
   parameter int TSEL_W = 2,
   parameter int IN_AW  = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              INPUT_WRITE,
   input  logic              TEMPLATE_WRITE,
   input  logic              FF_WRITE,
   input  logic              TC_WRITE,
   input  logic              INPUT_READ,
   input  logic              TEMPLATE_READ,
   input  logic              FF_READ,
   input  logic              TC_READ,
   input  logic [TSEL_W-1:0] TEMPLATE_BITS,
   input  logic [DATA_W-1:0] WRITE_DATA_0,
   input  logic [DATA_W-1:0] WRITE_DATA_1,
   output logic [DATA_W-1:0] READ_DATA_0,
   output logic [DATA_W-1:0] READ_DATA_1,
   output logic              READY,
   output logic              TEMPLATE_CHANGE,
   output logic [IN_AW:0]    IN_COUNT,
   output logic              IN_FULL,
   output logic              IN_EMPTY,
   output logic              ERR
);
   localparam int N_TMPL = 2**TSEL_W;
   localparam int DEPTH  = 2**IN_AW;
   localparam logic [IN_AW-1:0] PTR_ONE = 1;
   localparam logic [IN_AW:0]   CNT_ONE = 1;
   localparam logic [IN_AW:0]   CNT_MAX = DEPTH;

   typedef enum logic [2:0] {IDLE, WRITE, RD_ADDR, RD_WAIT, DONE} state_t;
   typedef enum logic [2:0] {C_IN_WR, C_TM_WR, C_FF_WR, C_TC_WR,
                             C_IN_RD, C_TM_RD, C_FF_RD, C_TC_RD} cmd_t;

   logic [DATA_W-1:0] fifo_mem [DEPTH];
   logic [DATA_W-1:0] tmpl_mem [N_TMPL];
   logic [DATA_W-1:0] ff0_mem  [N_TMPL];
   logic [DATA_W-1:0] ff1_mem  [N_TMPL];
   logic [DATA_W-1:0] tc_mem   [N_TMPL];

   state_t            state;
   cmd_t              cmd, next_cmd;
   logic [DATA_W-1:0] wd0, wd1, rd0_q, rd1_q;
   logic [TSEL_W-1:0] sel, last_tmpl, pop_sel;
   logic              skip;
   logic [IN_AW-1:0]  wr_ptr, rd_ptr;
   logic [7:0]        strobes;
   logic              multi;

   assign strobes  = {INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE,
                      INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ};
   assign multi    = (strobes & (strobes - 8'd1)) != 8'd0;
   assign IN_FULL  = IN_COUNT == CNT_MAX;
   assign IN_EMPTY = IN_COUNT == '0;
   assign pop_sel  = rd0_q[DATA_W-1 -: TSEL_W];

   always_comb begin
      next_cmd = C_TC_RD;
      if      (INPUT_WRITE)    next_cmd = C_IN_WR;
      else if (TEMPLATE_WRITE) next_cmd = C_TM_WR;
      else if (FF_WRITE)       next_cmd = C_FF_WR;
      else if (TC_WRITE)       next_cmd = C_TC_WR;
      else if (INPUT_READ)     next_cmd = C_IN_RD;
      else if (TEMPLATE_READ)  next_cmd = C_TM_RD;
      else if (FF_READ)        next_cmd = C_FF_RD;
   end

   // Storage has no reset so it maps onto block RAM; contents survive RST.
   always_ff @(posedge CLK) begin
      if (state == WRITE) begin
         case (cmd)
            C_IN_WR: if (!skip) fifo_mem[wr_ptr] <= wd0;
            C_TM_WR: tmpl_mem[sel] <= wd0;
            C_FF_WR: begin
               ff0_mem[sel] <= wd0;
               ff1_mem[sel] <= wd1;
            end
            C_TC_WR: tc_mem[sel] <= wd0;
            default: ;
         endcase
      end
      if (state == RD_ADDR) begin
         case (cmd)
            C_IN_RD: rd0_q <= fifo_mem[rd_ptr];
            C_TM_RD: rd0_q <= tmpl_mem[sel];
            C_FF_RD: rd0_q <= ff0_mem[sel];
            default: rd0_q <= tc_mem[sel];
         endcase
         rd1_q <= ff1_mem[sel];
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state           <= IDLE;
         cmd             <= C_IN_WR;
         READY           <= 1'b1;
         READ_DATA_0     <= '0;
         READ_DATA_1     <= '0;
         TEMPLATE_CHANGE <= 1'b0;
         ERR             <= 1'b0;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         IN_COUNT        <= '0;
         last_tmpl       <= '0;
         wd0             <= '0;
         wd1             <= '0;
         sel             <= '0;
         skip            <= 1'b0;
      end else begin
         TEMPLATE_CHANGE <= 1'b0;
         case (state)
            IDLE: if (strobes != 8'd0) begin
               READY <= 1'b0;
               cmd   <= next_cmd;
               wd0   <= WRITE_DATA_0;
               wd1   <= WRITE_DATA_1;
               skip  <= 1'b0;
               if (multi) ERR <= 1'b1;
               case (next_cmd)
                  C_IN_WR: begin
                     state <= WRITE;
                     if (IN_FULL) begin
                        skip <= 1'b1;
                        ERR  <= 1'b1;
                     end
                  end
                  C_TM_WR, C_TC_WR: begin
                     state <= WRITE;
                     sel   <= WRITE_DATA_0[DATA_W-1 -: TSEL_W];
                  end
                  C_FF_WR: begin
                     state <= WRITE;
                     sel   <= WRITE_DATA_1[DATA_W-1 -: TSEL_W];
                  end
                  C_IN_RD: begin
                     state <= RD_ADDR;
                     if (IN_EMPTY) begin
                        skip <= 1'b1;
                        ERR  <= 1'b1;
                     end
                  end
                  default: begin
                     state <= RD_ADDR;
                     sel   <= TEMPLATE_BITS;
                  end
               endcase
            end
            WRITE: begin
               state <= IDLE;
               READY <= 1'b1;
               if (cmd == C_IN_WR && !skip) begin
                  wr_ptr   <= wr_ptr + PTR_ONE;
                  IN_COUNT <= IN_COUNT + CNT_ONE;
               end
            end
            RD_ADDR: state <= RD_WAIT;
            RD_WAIT: state <= DONE;
            DONE: begin
               state <= IDLE;
               READY <= 1'b1;
               // Empty pops leave data and the last-template register untouched.
               if (cmd == C_IN_RD) begin
                  if (!skip) begin
                     READ_DATA_0     <= rd0_q;
                     rd_ptr          <= rd_ptr + PTR_ONE;
                     IN_COUNT        <= IN_COUNT - CNT_ONE;
                     last_tmpl       <= pop_sel;
                     TEMPLATE_CHANGE <= pop_sel != last_tmpl;
                  end
               end else begin
                  READ_DATA_0 <= rd0_q;
                  if (cmd == C_FF_RD) READ_DATA_1 <= rd1_q;
                  last_tmpl       <= sel;
                  TEMPLATE_CHANGE <= sel != last_tmpl;
               end
            end
            default: begin
               state <= IDLE;
               READY <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_pattern_mem_ctrl.sv
// tb/tb_pattern_mem_ctrl.sv - directed self-checking bench for pattern_mem_ctrl
module tb_pattern_mem_ctrl;
   localparam logic [7:0] S_IN_WR = 8'h80, S_TM_WR = 8'h40, S_FF_WR = 8'h20, S_TC_WR = 8'h10;
   localparam logic [7:0] S_IN_RD = 8'h08, S_TM_RD = 8'h04, S_FF_RD = 8'h02, S_TC_RD = 8'h01;
   localparam logic [127:0] VA = 128'h0123FEEDDEADBEEF0123FEEDDEADBEEF;
   localparam logic [127:0] VC = 128'hC123FEEDDEADBEEF0123FEEDDEADBEEF;
   localparam logic [127:0] VF = 128'hFEEDFACECAFEBABE0123456789ABAAAA;

   logic         CLK = 1'b0;
   logic         RST;
   logic         INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE;
   logic         INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ;
   logic [1:0]   TEMPLATE_BITS;
   logic [127:0] WRITE_DATA_0, WRITE_DATA_1, READ_DATA_0, READ_DATA_1;
   logic         READY, TEMPLATE_CHANGE, IN_FULL, IN_EMPTY, ERR;
   logic [4:0]   IN_COUNT;

   int checks = 0;
   int errors = 0;
   int lat;
   logic tchg;

   pattern_mem_ctrl dut (
      .CLK(CLK), .RST(RST),
      .INPUT_WRITE(INPUT_WRITE), .TEMPLATE_WRITE(TEMPLATE_WRITE), .FF_WRITE(FF_WRITE),
      .TC_WRITE(TC_WRITE), .INPUT_READ(INPUT_READ), .TEMPLATE_READ(TEMPLATE_READ),
      .FF_READ(FF_READ), .TC_READ(TC_READ), .TEMPLATE_BITS(TEMPLATE_BITS),
      .WRITE_DATA_0(WRITE_DATA_0), .WRITE_DATA_1(WRITE_DATA_1),
      .READ_DATA_0(READ_DATA_0), .READ_DATA_1(READ_DATA_1), .READY(READY),
      .TEMPLATE_CHANGE(TEMPLATE_CHANGE), .IN_COUNT(IN_COUNT), .IN_FULL(IN_FULL),
      .IN_EMPTY(IN_EMPTY), .ERR(ERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_strobes(input logic [7:0] stb);
      {INPUT_WRITE, TEMPLATE_WRITE, FF_WRITE, TC_WRITE,
       INPUT_READ, TEMPLATE_READ, FF_READ, TC_READ} = stb;
   endtask

   // Issue one command and wait (bounded) for READY; lat counts cycles READY stayed low.
   task automatic do_cmd(input logic [7:0] stb, input logic [127:0] d0, input logic [127:0] d1,
                         input logic [1:0] tb, output int n, output logic tc);
      set_strobes(stb);
      WRITE_DATA_0  = d0;
      WRITE_DATA_1  = d1;
      TEMPLATE_BITS = tb;
      @(posedge CLK); #1;
      set_strobes(8'h00);
      n = 0;
      while (!READY && n < 20) begin
         @(posedge CLK); #1;
         n++;
      end
      tc = TEMPLATE_CHANGE;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   function automatic logic [127:0] pat(input int i);
      logic [127:0] w;
      w = '0;
      w[127:126] = 2'(i);
      w[31:0] = 32'hA5000000 + 32'(i);
      return w;
   endfunction

   initial begin
      set_strobes(8'h00);
      WRITE_DATA_0 = '0;
      WRITE_DATA_1 = '0;
      TEMPLATE_BITS = '0;
      do_reset();
      check("rst_ready", 128'(READY), 128'd1);
      check("rst_rd0", READ_DATA_0, '0);
      check("rst_rd1", READ_DATA_1, '0);
      check("rst_tchg", 128'(TEMPLATE_CHANGE), 128'd0);
      check("rst_err", 128'(ERR), 128'd0);
      check("rst_count", 128'(IN_COUNT), 128'd0);
      check("rst_empty", 128'(IN_EMPTY), 128'd1);
      check("rst_full", 128'(IN_FULL), 128'd0);

      do_cmd(S_TC_WR, VA, '0, 2'd0, lat, tchg);
      check("tc_wr_lat", 128'(lat), 128'd1);
      do_cmd(S_TC_RD, '0, '0, 2'd0, lat, tchg);
      check("tc_rd_data", READ_DATA_0, VA);
      check("tc_rd_lat", 128'(lat), 128'd3);
      check("tc_rd_tchg", 128'(tchg), 128'd0);

      do_cmd(S_TM_WR, VA, '0, 2'd0, lat, tchg);
      do_cmd(S_TM_WR, VC, '0, 2'd0, lat, tchg);
      do_cmd(S_TM_RD, '0, '0, 2'd3, lat, tchg);
      check("tm_rd3_data", READ_DATA_0, VC);
      check("tm_rd3_tchg", 128'(tchg), 128'd1);
      do_cmd(S_TM_RD, '0, '0, 2'd0, lat, tchg);
      check("tm_rd0_data", READ_DATA_0, VA);
      check("tm_rd0_tchg", 128'(tchg), 128'd1);

      do_cmd(S_FF_WR, VA, VC, 2'd0, lat, tchg);
      do_cmd(S_FF_RD, '0, '0, 2'd3, lat, tchg);
      check("ff_rd_d0", READ_DATA_0, VA);
      check("ff_rd_d1", READ_DATA_1, VC);
      do_cmd(S_TM_RD, '0, '0, 2'd0, lat, tchg);
      check("rd1_hold", READ_DATA_1, VC);

      do_cmd(S_IN_WR, VA, '0, 2'd0, lat, tchg);
      do_cmd(S_IN_WR, VF, '0, 2'd0, lat, tchg);
      check("fifo_cnt2", 128'(IN_COUNT), 128'd2);
      do_cmd(S_IN_RD, '0, '0, 2'd0, lat, tchg);
      check("pop1_data", READ_DATA_0, VA);
      check("pop1_cnt", 128'(IN_COUNT), 128'd1);
      check("pop1_tchg", 128'(tchg), 128'd0);
      do_cmd(S_IN_RD, '0, '0, 2'd0, lat, tchg);
      check("pop2_data", READ_DATA_0, VF);
      check("pop2_cnt", 128'(IN_COUNT), 128'd0);
      check("pop2_tchg", 128'(tchg), 128'd1);
      check("pop2_empty", 128'(IN_EMPTY), 128'd1);
      check("pop2_err", 128'(ERR), 128'd0);

      for (int i = 0; i < 16; i++) do_cmd(S_IN_WR, pat(i), '0, 2'd0, lat, tchg);
      check("fill_cnt", 128'(IN_COUNT), 128'd16);
      check("fill_full", 128'(IN_FULL), 128'd1);
      check("fill_err", 128'(ERR), 128'd0);
      do_cmd(S_IN_WR, VF, '0, 2'd0, lat, tchg);
      check("ovf_err", 128'(ERR), 128'd1);
      check("ovf_cnt", 128'(IN_COUNT), 128'd16);
      check("ovf_lat", 128'(lat), 128'd1);
      for (int i = 0; i < 16; i++) begin
         do_cmd(S_IN_RD, '0, '0, 2'd0, lat, tchg);
         check($sformatf("drain_%0d", i), READ_DATA_0, pat(i));
      end
      check("drain_cnt", 128'(IN_COUNT), 128'd0);
      check("drain_empty", 128'(IN_EMPTY), 128'd1);
      do_cmd(S_IN_RD, '0, '0, 2'd0, lat, tchg);
      check("udf_data", READ_DATA_0, pat(15));
      check("udf_err", 128'(ERR), 128'd1);
      check("udf_lat", 128'(lat), 128'd3);

      do_reset();
      check("rst2_err", 128'(ERR), 128'd0);
      do_cmd(S_TM_RD | S_TC_RD, '0, '0, 2'd3, lat, tchg);
      check("multi_data", READ_DATA_0, VC);
      check("multi_err", 128'(ERR), 128'd1);

      do_reset();
      TEMPLATE_BITS = 2'd0;
      set_strobes(S_TM_RD);
      @(posedge CLK); #1;
      set_strobes(S_IN_WR);
      WRITE_DATA_0 = VF;
      repeat (3) @(posedge CLK);
      #1 set_strobes(8'h00);
      check("busy_ready", 128'(READY), 128'd1);
      check("busy_err", 128'(ERR), 128'd0);
      check("busy_cnt", 128'(IN_COUNT), 128'd0);
      check("busy_data", READ_DATA_0, VA);

      TEMPLATE_BITS = 2'd0;
      set_strobes(S_TC_RD | S_FF_RD);
      @(posedge CLK); #1;
      set_strobes(8'h00);
      @(posedge CLK); #1;
      RST = 1'b1;
      @(posedge CLK); #1;
      check("abort_ready", 128'(READY), 128'd1);
      check("abort_rd0", READ_DATA_0, '0);
      check("abort_err", 128'(ERR), 128'd0);
      check("abort_tchg", 128'(TEMPLATE_CHANGE), 128'd0);
      RST = 1'b0;
      @(posedge CLK); #1;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
